// File: rtl/tt_serial_adder_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tt_serial_adder_pkg : shared state encoding and pin-index constants.
// Revision 1.0
// ---------------------------------------------------------------------------
package tt_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int UI_A_BIT   = 0;
    localparam int UI_B_BIT   = 1;
    localparam int UI_START   = 2;
    localparam int UI_SUB     = 3;
    localparam int UI_CHAIN   = 4;
    localparam int UI_BSEL_LO = 5;

    localparam int UO_SUM   = 0;
    localparam int UO_CARRY = 1;
    localparam int UO_BUSY  = 2;
    localparam int UO_DONE  = 3;
    localparam int UO_OVF   = 4;

endpackage
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_fa_cell : combinational 1-bit full adder slice.
// Revision 1.0
// ---------------------------------------------------------------------------
module serial_fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule
`default_nettype wire

// File: rtl/tt_um_kris_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tt_um_kris_serial_adder : bit-serial add/subtract with carry chaining.
// Revision 1.0
// ---------------------------------------------------------------------------
module tt_um_kris_serial_adder
    import tt_serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               sum_q, sum_d;
    logic               sub_q, sub_d;

    logic               w_s;
    logic               w_cout;
    logic [63:0]        w_res_ext;
    logic               w_unused;

    assign w_unused = ^uio_in;

    // Subtraction inverts B; the +1 comes from the initial carry.
    serial_fa_cell u_fa (
        .a_i    (ui_in[UI_A_BIT]),
        .b_i    (ui_in[UI_B_BIT] ^ sub_q),
        .cin_i  (carry_q),
        .s_o    (w_s),
        .cout_o (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sum_q    <= 1'b0;
            sub_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            sum_q    <= sum_d;
            sub_q    <= sub_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sum_d    = sum_q;
        sub_d    = sub_q;
        if (ena) begin
            case (state_q)
                IDLE: begin
                    if (ui_in[UI_START]) begin
                        sub_d   = ui_in[UI_SUB];
                        cnt_d   = '0;
                        carry_d = ui_in[UI_CHAIN] ? carry_q : ui_in[UI_SUB];
                        state_d = RUN;
                    end
                end
                RUN: begin
                    result_d = {w_s, result_q[WIDTH-1:1]};
                    sum_d    = w_s;
                    carry_d  = w_cout;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        ovf_d   = carry_q ^ w_cout;
                        state_d = DONE;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        uo_out           = 8'h00;
        uo_out[UO_SUM]   = sum_q;
        uo_out[UO_CARRY] = carry_q;
        uo_out[UO_BUSY]  = (state_q == RUN);
        uo_out[UO_DONE]  = (state_q == DONE);
        uo_out[UO_OVF]   = ovf_q;
    end

    // Zero-extension makes unused high bits and out-of-range bytes read 0.
    assign w_res_ext = {{(64 - WIDTH){1'b0}}, result_q};
    assign uio_out   = w_res_ext[{ui_in[UI_BSEL_LO +: 3], 3'b000} +: 8];
    assign uio_oe    = 8'hFF;

endmodule
`default_nettype wire

// File: tb/tb_tt_um_kris_serial_adder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tt_um_kris_serial_adder : directed scoreboard bench, WIDTH 8 and 16.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_tt_um_kris_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui8, ui16;
    logic [7:0] uo8, uo16, uio8, uio16, oe8, oe16;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_done = 0;
    int   prev_done = 0;
    logic mc8 = 1'b0;
    logic mc16 = 1'b0;

    typedef struct {
        string       tag;
        logic [15:0] res;
        logic        c;
        logic        v;
    } exp_t;

    exp_t sb[$];

    tt_um_kris_serial_adder #(.WIDTH(8)) u8 (
        .ui_in(ui8), .uo_out(uo8), .uio_in(8'h00), .uio_out(uio8),
        .uio_oe(oe8), .ena(ena), .clk(clk), .rst_n(rst_n)
    );

    tt_um_kris_serial_adder #(.WIDTH(16)) u16 (
        .ui_in(ui16), .uo_out(uo16), .uio_in(8'h00), .uio_out(uio16),
        .uio_oe(oe16), .ena(ena), .clk(clk), .rst_n(rst_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] get_uo(input int w);
        return (w == 8) ? uo8 : uo16;
    endfunction

    function automatic logic [7:0] get_uio(input int w);
        return (w == 8) ? uio8 : uio16;
    endfunction

    task automatic set_ui(input int w, input logic [7:0] v);
        if (w == 8) ui8 = v;
        else        ui16 = v;
    endtask

    task automatic do_op(input string tag, input int w, input logic [15:0] a, input logic [15:0] b,
                         input bit sub, input bit chain, input bit hold,
                         input int stall_at, input int abort_at);
        logic [15:0] mask;
        logic [15:0] bb;
        logic [16:0] full;
        logic        cin;
        logic [7:0]  t;
        exp_t        e;
        int          n;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        bb   = sub ? (~b & mask) : (b & mask);
        cin  = chain ? ((w == 8) ? mc8 : mc16) : sub;
        full = {1'b0, a & mask} + {1'b0, bb} + 17'(cin);
        e.tag = tag;
        e.res = full[15:0] & mask;
        e.c   = full[w];
        e.v   = (a[w-1] == bb[w-1]) && (e.res[w-1] != a[w-1]);
        sb.push_back(e);
        if (w == 8) mc8 = e.c;
        else        mc16 = e.c;

        @(negedge clk);
        set_ui(w, {3'b000, chain, sub, 1'b1, 2'b00});
        n = 0;
        for (int i = 0; i < w; i++) begin
            @(negedge clk);
            n++;
            if (i == 0) begin
                t = get_uo(w);
                check({tag, ":busy"}, {31'd0, t[2]}, 32'd1);
            end
            set_ui(w, {3'b000, chain, sub, hold, b[i], a[i]});
            if (i == stall_at) begin
                ena = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    n++;
                end
                t = get_uo(w);
                check({tag, ":stall_busy_done"}, {30'd0, t[3:2]}, 32'd1);
                ena = 1'b1;
            end
            if (i == abort_at) begin
                @(posedge clk);
                rst_n = 1'b0;
                #1;
                check({tag, ":abort_uo"}, {24'd0, get_uo(w)}, 32'h00);
                check({tag, ":abort_uio"}, {24'd0, get_uio(w)}, 32'h00);
                check({tag, ":abort_oe"}, {24'd0, oe8}, 32'hFF);
                @(negedge clk);
                rst_n = 1'b1;
                set_ui(w, 8'h00);
                void'(sb.pop_back());
                mc8  = 1'b0;
                mc16 = 1'b0;
                return;
            end
        end
        t = 8'h00;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n++;
            t = get_uo(w);
            if (t[3]) break;
        end
        check({tag, ":done"}, {31'd0, t[3]}, 32'd1);
        check({tag, ":latency"}, n, w + 1 + ((stall_at >= 0) ? 3 : 0));
        prev_done = last_done;
        last_done = cyc;

        set_ui(w, {3'b000, 2'b00, hold, 2'b00});
        #1;
        if (sb.size() == 0) begin
            check({tag, ":sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ":res_b0"}, {24'd0, get_uio(w)}, {24'd0, e.res[7:0]});
            check({e.tag, ":carry"}, {31'd0, t[1]}, {31'd0, e.c});
            check({e.tag, ":ovf"}, {31'd0, t[4]}, {31'd0, e.v});
            check({e.tag, ":sum_bit"}, {31'd0, t[0]}, {31'd0, e.res[w-1]});
            set_ui(w, {3'b001, 2'b00, hold, 2'b00});
            #1;
            check({e.tag, ":res_b1"}, {24'd0, get_uio(w)}, (w == 16) ? {24'd0, e.res[15:8]} : 32'd0);
            if (w == 16) begin
                set_ui(w, {3'b101, 2'b00, hold, 2'b00});
                #1;
                check({e.tag, ":res_b5"}, {24'd0, get_uio(w)}, 32'd0);
            end
        end
        set_ui(w, {3'b000, 2'b00, hold, 2'b00});
    endtask

    initial begin
        logic [7:0] t;
        rst_n = 1'b0;
        ena   = 1'b1;
        ui8   = 8'h00;
        ui16  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_uo8", {24'd0, uo8}, 32'h00);
        check("rst_uio8", {24'd0, uio8}, 32'h00);
        check("rst_oe8", {24'd0, oe8}, 32'hFF);
        check("rst_uo16", {24'd0, uo16}, 32'h00);
        check("rst_uio16", {24'd0, uio16}, 32'h00);
        check("rst_oe16", {24'd0, oe16}, 32'hFF);
        rst_n = 1'b1;

        do_op("add5A33", 8, 16'h5A, 16'h33, 1'b0, 1'b0, 1'b0, -1, -1);
        @(negedge clk);
        t = uo8;
        check("done_drop", {30'd0, t[3:2]}, 32'd0);

        do_op("sub10_01", 8, 16'h10, 16'h01, 1'b1, 1'b0, 1'b0, -1, -1);
        do_op("sub00_01", 8, 16'h00, 16'h01, 1'b1, 1'b0, 1'b0, -1, -1);
        do_op("addFF01",  8, 16'hFF, 16'h01, 1'b0, 1'b0, 1'b0, -1, -1);
        do_op("chain00",  8, 16'h00, 16'h00, 1'b0, 1'b1, 1'b0, -1, -1);
        do_op("w16add",   16, 16'h1234, 16'h0F0F, 1'b0, 1'b0, 1'b0, -1, -1);
        do_op("w16sub",   16, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0, -1, -1);
        do_op("stall",    8, 16'h3C, 16'h0F, 1'b0, 1'b0, 1'b0, 3, -1);

        @(negedge clk);
        ena = 1'b0;
        ui8 = 8'h04;
        repeat (2) @(negedge clk);
        ui8 = 8'h00;
        ena = 1'b1;
        @(negedge clk);
        t = uo8;
        check("ena_start_ignored", {31'd0, t[2]}, 32'd0);

        do_op("hold1", 8, 16'h21, 16'h42, 1'b0, 1'b0, 1'b1, -1, -1);
        do_op("hold2", 8, 16'h7F, 16'h01, 1'b0, 1'b0, 1'b1, -1, -1);
        check("hold_interval", last_done - prev_done, 32'd10);
        ui8 = 8'h00;
        @(negedge clk);

        do_op("abort", 8, 16'hAA, 16'h55, 1'b0, 1'b0, 1'b0, -1, 3);
        do_op("chain_after_rst", 8, 16'h01, 16'h02, 1'b0, 1'b1, 1'b0, -1, -1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
